reg_file_mp: RTL
================

// Module: reg_file_mp
// PURPOSE
//  Parametrised multi-port ARM-style register file, the next generation of the core's register file.
//  Adds a second write port, write-through bypass, synchronous reset, PC hold (pc_en) and a parametric PC wrap limit.
//  Sits between decode (operand reads) and execute/writeback (ALU result on port 0, load/base update on port 1).
//  Owns the PC register and the BL link update.
// PARAMETERS
//  DATA_W    32  register width
//  ADDR_W    4   register address width; NREGS = 2**ADDR_W
//  NRD       4   number of combinational read ports
//  PC_IDX    15  index of program counter register
//  LR_IDX    14  index of link register
//  PC_STEP   4   link offset added on BL
//  PC_LIMIT  60  PC wraps to 0 when committed value > PC_LIMIT
//  BYPASS    1   1: reads see same-cycle write data; 0: reads see registered state only
// PORTS
//  clk      in   1             clock, all state updates on posedge
//  rst      in   1             synchronous reset, active-high
//  rd_addr  in   NRD*ADDR_W    read addresses, port k at [k*ADDR_W +: ADDR_W]
//  rd_data  out  NRD*DATA_W    read data, port k at [k*DATA_W +: DATA_W]
//  wen0     in   1             write enable, port 0 (ALU writeback)
//  waddr0   in   ADDR_W        write address, port 0
//  wdata0   in   DATA_W        write data, port 0
//  wen1     in   1             write enable, port 1 (load / base writeback)
//  waddr1   in   ADDR_W        write address, port 1
//  wdata1   in   DATA_W        write data, port 1
//  pc_en    in   1             1: PC advances this cycle; 0: PC holds unless explicitly written
//  pc_next  in   DATA_W        sequential/branch next PC from fetch
//  ctrl_bl  in   1             branch-with-link: update LR this cycle
//  pc_out   out  DATA_W        registered PC (fetch address)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): every register, including PC and LR, becomes 0.
//    rst overrides every write, BL and pc_en. pc_out=0 and all rd_data reflect 0 (plus bypass) the next cycle.
//  - Reads: combinational, zero latency. rd_data[k] = R[rd_addr[k]].
//  - Bypass (BYPASS=1, non-PC address): if wen0 && waddr0==rd_addr[k], return wdata0;
//    else if wen1 && waddr1==rd_addr[k], return wdata1. Port 0 has priority.
//    Reads of PC_IDX always return the registered PC (never bypassed).
//  - GPR writes (addr != PC_IDX): on the posedge, R[waddr] <= wdata.
//    Both ports to the same address: port 0 wins, port 1 is dropped.
//  - PC candidate, highest priority first:
//    1. wdata0 if wen0 && waddr0==PC_IDX
//    2. wdata1 if wen1 && waddr1==PC_IDX
//    3. pc_next if pc_en
//    4. current PC otherwise
//  - PC commit: PC <= (cand > PC_LIMIT, unsigned) ? 0 : cand. A wrap also applies to explicit PC writes.
//  - BL: if ctrl_bl, LR <= committed_PC + PC_STEP, modulo 2**DATA_W.
//    BL overrides any same-cycle port write to LR_IDX. BL with pc_en=0 links the held PC.
//  - There is no FSM. State is the register array plus PC; every update is single-cycle.
// STRUCTURE
//  - reg_file_pkg: DATA_W/ADDR_W defaults, PC_IDX, LR_IDX, PC_STEP, PC_LIMIT, and typedef reg_addr_t / reg_data_t.
//  - Sub-module reg_file_pc_unit: computes the PC candidate, wrap, committed PC and link value (combinational).
//    The top level holds the array, write arbitration and bypass muxes (generate loop over NRD).
// TESTING
//  1. Reset: preload R3=0x55, pulse rst -> R3=0, pc_out=0; with rst held, wen0=1 to R3 -> R3 stays 0.
//  2. Bypass: wen0=1 waddr0=5 wdata0=0xAA, rd_addr[0]=5 in the same cycle -> rd_data[0]=0xAA (BYPASS=0: old value).
//     Next cycle -> 0xAA in both builds.
//  3. Port conflict: wen0=wen1=1 to R7 with 0x11 / 0x22 -> R7=0x11; bypass read also shows 0x11.
//  4. PC: pc_en=1, pc_next=56 -> pc_out=56; pc_next=64 -> pc_out=0; pc_en=0 -> pc_out holds;
//     wen1 to PC_IDX with 20 -> pc_out=20.
//  5. BL: pc_next=16, ctrl_bl=1, wen0 to R14 with 0x99 -> pc_out=16, R14=20 (BL wins).
//  6. Random: 10k cycles vs. a reference model, all ports random, rst asserted at 1% -> exact match every cycle.

Source files
------------

// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - default geometry, special register indices and types for the register file
package reg_file_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_NRD      = 4;
  localparam int DEF_PC_IDX   = 15;
  localparam int DEF_LR_IDX   = 14;
  localparam int DEF_PC_STEP  = 4;
  localparam int DEF_PC_LIMIT = 60;

  typedef logic [DEF_DATA_W-1:0] reg_data_t;
  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_mp_if.sv
// rtl/reg_file_mp_if.sv - read, write, PC and link bundle between pipeline stages and the register file
interface reg_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NRD    = 4
);

  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic                  wen0;
  logic [ADDR_W-1:0]     waddr0;
  logic [DATA_W-1:0]     wdata0;
  logic                  wen1;
  logic [ADDR_W-1:0]     waddr1;
  logic [DATA_W-1:0]     wdata1;
  logic                  pc_en;
  logic [DATA_W-1:0]     pc_next;
  logic                  ctrl_bl;
  logic [DATA_W-1:0]     pc_out;

  modport master (
    output rd_addr, wen0, waddr0, wdata0, wen1, waddr1, wdata1, pc_en, pc_next, ctrl_bl,
    input  rd_data, pc_out
  );

  modport slave (
    input  rd_addr, wen0, waddr0, wdata0, wen1, waddr1, wdata1, pc_en, pc_next, ctrl_bl,
    output rd_data, pc_out
  );

endinterface

// File: rtl/reg_file_pc_unit.sv
// rtl/reg_file_pc_unit.sv - next-PC selection with wrap limit and BL link value
import reg_file_pkg::*;

module reg_file_pc_unit #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int PC_IDX   = DEF_PC_IDX,
  parameter int PC_STEP  = DEF_PC_STEP,
  parameter int PC_LIMIT = DEF_PC_LIMIT
) (
  input  logic [DATA_W-1:0] cur_pc,
  input  logic              wen0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              wen1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              pc_en,
  input  logic [DATA_W-1:0] pc_next,
  output logic [DATA_W-1:0] pc_commit,
  output logic [DATA_W-1:0] link
);

  logic [DATA_W-1:0] cand;

  always_comb begin
    cand = cur_pc;
    if (wen0 && waddr0 == ADDR_W'(PC_IDX)) begin
      cand = wdata0;
    end else if (wen1 && waddr1 == ADDR_W'(PC_IDX)) begin
      cand = wdata1;
    end else if (pc_en) begin
      cand = pc_next;
    end
  end

  // Wrap applies to explicit PC writes too, so software cannot park the PC past the limit.
  assign pc_commit = (cand > DATA_W'(PC_LIMIT)) ? '0 : cand;
  assign link      = pc_commit + DATA_W'(PC_STEP);

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - dual-write, multi-read register file with bypass, PC register and BL link
import reg_file_pkg::*;

module reg_file_mp #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NRD      = DEF_NRD,
  parameter int PC_IDX   = DEF_PC_IDX,
  parameter int LR_IDX   = DEF_LR_IDX,
  parameter int PC_STEP  = DEF_PC_STEP,
  parameter int PC_LIMIT = DEF_PC_LIMIT,
  parameter bit BYPASS   = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_mp_if.slave  rf
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] pc_commit;
  logic [DATA_W-1:0] link;

  reg_file_pc_unit #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .PC_IDX   (PC_IDX),
    .PC_STEP  (PC_STEP),
    .PC_LIMIT (PC_LIMIT)
  ) u_pc_unit (
    .cur_pc    (pc_q),
    .wen0      (rf.wen0),
    .waddr0    (rf.waddr0),
    .wdata0    (rf.wdata0),
    .wen1      (rf.wen1),
    .waddr1    (rf.waddr1),
    .wdata1    (rf.wdata1),
    .pc_en     (rf.pc_en),
    .pc_next   (rf.pc_next),
    .pc_commit (pc_commit),
    .link      (link)
  );

  // Later assignments win: port 1, then port 0, then BL to LR.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      pc_q <= '0;
    end else begin
      pc_q <= pc_commit;
      if (rf.wen1 && rf.waddr1 != ADDR_W'(PC_IDX)) begin
        regs[rf.waddr1] <= rf.wdata1;
      end
      if (rf.wen0 && rf.waddr0 != ADDR_W'(PC_IDX)) begin
        regs[rf.waddr0] <= rf.wdata0;
      end
      if (rf.ctrl_bl) begin
        regs[LR_IDX] <= link;
      end
    end
  end

  assign rf.pc_out = pc_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] val;

    assign addr = rf.rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      val = regs[addr];
      if (addr == ADDR_W'(PC_IDX)) begin
        val = pc_q;
      end else if (BYPASS && rf.wen0 && rf.waddr0 == addr) begin
        val = rf.wdata0;
      end else if (BYPASS && rf.wen1 && rf.waddr1 == addr) begin
        val = rf.wdata1;
      end
    end

    assign rf.rd_data[k*DATA_W +: DATA_W] = val;
  end

endmodule
